// File: rtl/multicycle_control_pkg.sv
// cpu_ctrl_pkg: opcodes, ALU/imm codes, status bit indices, FSM states and control word shared by the multicycle controller.
package cpu_ctrl_pkg;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_C = 2;
    localparam int ST_V = 3;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef struct packed {
        logic       regRW;
        logic       ALUsrc;
        logic [1:0] immsrc;
        logic [4:0] ALUop;
        logic       mRW;
        logic       wb;
        logic       pc_en;
    } ctrl_t;
    localparam ctrl_t CTRL_DEF = '{regRW: 1'b0, ALUsrc: 1'b1, immsrc: IMM_I, ALUop: ALU_ADD,
                                   mRW: 1'b1, wb: 1'b0, pc_en: 1'b0};
    function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic n, input logic v);
        return f3 == 3'b000 ? z : f3 == 3'b001 ? !z : f3 == 3'b100 ? (n ^ v) : f3 == 3'b101 ? !(n ^ v) : 1'b0;
    endfunction
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction/status inputs and per-state control outputs between controller and datapath.
interface multicycle_control_if #(parameter int CNT_W = 32);
    logic [31:0]      instr;
    logic [3:0]       status;
    logic             regRW;
    logic             ALUsrc;
    logic [1:0]       immsrc;
    logic [4:0]       ALUop;
    logic             mRW;
    logic             wb;
    logic             pcsrc;
    logic             pc_en;
    logic             illegal;
    logic [CNT_W-1:0] retired;
    modport master (input instr, status,
                    output regRW, ALUsrc, immsrc, ALUop, mRW, wb, pcsrc, pc_en, illegal, retired);
    modport slave  (output instr, status,
                    input regRW, ALUsrc, immsrc, ALUop, mRW, wb, pcsrc, pc_en, illegal, retired);
endinterface

// File: rtl/multicycle_control_alu_dec.sv
// alu_dec: maps opcode/funct3/funct7 to an ALU operation and flags unsupported encodings.
module alu_dec
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [4:0] alu_op,
    output logic       legal
);
    logic [4:0] base;
    logic       f7_zero;
    logic       f7_alt;
    always_comb begin
        f7_zero = funct7 == 7'b0000000;
        f7_alt  = funct7 == 7'b0100000;
        case (funct3)
            3'b000:  base = ALU_ADD;
            3'b001:  base = ALU_SLL;
            3'b010:  base = ALU_SLT;
            3'b011:  base = ALU_SLTU;
            3'b100:  base = ALU_XOR;
            3'b101:  base = ALU_SRL;
            3'b110:  base = ALU_OR;
            default: base = ALU_AND;
        endcase
        alu_op = ALU_ADD;
        legal  = 1'b0;
        case (opcode)
            OP_R: begin
                alu_op = !f7_alt ? base : funct3 == 3'b000 ? ALU_SUB : ALU_SRA;
                legal  = f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            // funct7 is part of the immediate except for shifts
            OP_I: begin
                alu_op = (funct3 == 3'b101 && f7_alt) ? ALU_SRA : base;
                legal  = funct3 == 3'b001 ? f7_zero : funct3 == 3'b101 ? (f7_zero || f7_alt) : 1'b1;
            end
            OP_LW, OP_SW: legal = funct3 == 3'b010;
            OP_B: begin
                alu_op = ALU_SUB;
                legal  = funct3 inside {3'b000, 3'b001, 3'b100, 3'b101};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH..WB controller spreading one instruction over several cycles with one pc_en per instruction.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter bit HALT_ILLEG = 1'b1
) (
    input logic clk,
    input logic rst,
    multicycle_control_if.master bus
);
    state_t           state;
    logic [31:0]      ir;
    ctrl_t            ctrl;
    logic             br_exec;
    logic             ill;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       alu_op;
    logic             legal;
    logic [6:0]       opc;
    logic             unused_bits;
    assign opc = ir[6:0];
    alu_dec u_dec (.opcode(ir[6:0]), .funct3(ir[14:12]), .funct7(ir[31:25]), .alu_op(alu_op), .legal(legal));
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            ir      <= '0;
            ctrl    <= CTRL_DEF;
            br_exec <= 1'b0;
            ill     <= 1'b0;
            cnt     <= '0;
        end else begin
            ctrl    <= CTRL_DEF;
            br_exec <= 1'b0;
            cnt     <= cnt + CNT_W'(ctrl.pc_en);
            case (state)
                S_FETCH: begin
                    ir    <= bus.instr;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (!legal && HALT_ILLEG) begin
                        state <= S_HALT;
                        ill   <= 1'b1;
                    end else if (!legal) begin
                        state       <= S_WB;
                        ctrl.pc_en  <= 1'b1;
                    end else begin
                        state       <= S_EXEC;
                        ctrl.ALUsrc <= opc == OP_R || opc == OP_B;
                        ctrl.immsrc <= opc == OP_SW ? IMM_S : opc == OP_B ? IMM_B : IMM_I;
                        ctrl.ALUop  <= alu_op;
                        ctrl.pc_en  <= opc == OP_B;
                        br_exec     <= opc == OP_B;
                    end
                end
                // ALU controls stay put after EXEC: the datapath has no result latch
                S_EXEC: begin
                    state <= opc == OP_B ? S_FETCH : (opc == OP_LW || opc == OP_SW) ? S_MEM : S_WB;
                    if (opc != OP_B) begin
                        ctrl.ALUsrc <= ctrl.ALUsrc;
                        ctrl.immsrc <= ctrl.immsrc;
                        ctrl.ALUop  <= ctrl.ALUop;
                    end
                    ctrl.regRW <= opc == OP_R || opc == OP_I;
                    ctrl.mRW   <= opc != OP_SW;
                    ctrl.pc_en <= opc != OP_B && opc != OP_LW;
                end
                S_MEM: begin
                    state <= opc == OP_LW ? S_WB : S_FETCH;
                    if (opc == OP_LW) begin
                        ctrl.ALUsrc <= ctrl.ALUsrc;
                        ctrl.immsrc <= ctrl.immsrc;
                        ctrl.ALUop  <= ctrl.ALUop;
                        ctrl.regRW  <= 1'b1;
                        ctrl.wb     <= 1'b1;
                        ctrl.pc_en  <= 1'b1;
                    end
                end
                S_WB:    state <= S_FETCH;
                default: ;
            endcase
        end
    end
    assign bus.regRW   = ctrl.regRW;
    assign bus.ALUsrc  = ctrl.ALUsrc;
    assign bus.immsrc  = ctrl.immsrc;
    assign bus.ALUop   = ctrl.ALUop;
    assign bus.mRW     = ctrl.mRW;
    assign bus.wb      = ctrl.wb;
    assign bus.pc_en   = ctrl.pc_en;
    assign bus.pcsrc   = !(br_exec && br_taken(ir[14:12], bus.status[ST_Z], bus.status[ST_N], bus.status[ST_V]));
    assign bus.illegal = ill;
    assign bus.retired = cnt;
    assign unused_bits = ^{ir[24:15], ir[11:7], bus.status[ST_C]};
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-timeline model checks two controller configurations every cycle.
module tb_multicycle_control;
    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] SUB  = 32'h40208233;
    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] SRAI = 32'h4030D113;
    localparam logic [31:0] LW   = 32'h00802283;
    localparam logic [31:0] SW   = 32'h00502623;
    localparam logic [31:0] BEQ  = 32'hFE108CE3;
    localparam logic [31:0] BNE  = 32'hFE109CE3;
    localparam logic [31:0] BLT  = 32'hFE10CCE3;
    localparam logic [31:0] BGE  = 32'hFE10DCE3;
    localparam logic [31:0] JUNK = 32'hFFFFFFFF;

    typedef struct packed {
        logic regRW; logic ALUsrc; logic [1:0] immsrc; logic [4:0] ALUop;
        logic mRW; logic wb; logic pc_en; logic br; logic [2:0] f3;
    } ent_t;
    typedef struct packed {
        logic regRW; logic ALUsrc; logic [1:0] immsrc; logic [4:0] ALUop;
        logic mRW; logic wb; logic pcsrc; logic pc_en; logic illegal; logic [31:0] retired;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_s = 1'b1;
    logic [31:0] instr = ADD;
    logic [3:0]  status = 4'b0000;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    ent_t        q[2][$];
    logic        halted[2];
    logic [31:0] mc[2];
    obs_t        last[2];
    obs_t        a0, a1;

    multicycle_control_if #(.CNT_W(32)) b0();
    multicycle_control_if #(.CNT_W(4))  b1();
    assign b0.instr = instr;
    assign b0.status = status;
    assign b1.instr = instr;
    assign b1.status = status;
    multicycle_control #(.CNT_W(32), .HALT_ILLEG(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    multicycle_control #(.CNT_W(4),  .HALT_ILLEG(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    assign a0 = {b0.regRW, b0.ALUsrc, b0.immsrc, b0.ALUop, b0.mRW, b0.wb, b0.pcsrc, b0.pc_en, b0.illegal, b0.retired};
    assign a1 = {b1.regRW, b1.ALUsrc, b1.immsrc, b1.ALUop, b1.mRW, b1.wb, b1.pcsrc, b1.pc_en, b1.illegal, 28'd0, b1.retired};

    always #5 clk = ~clk;

    function automatic logic [4:0] base_op(input logic [2:0] f3);
        case (f3)
            3'd0: return 5'd0;
            3'd1: return 5'd5;
            3'd2: return 5'd8;
            3'd3: return 5'd9;
            3'd4: return 5'd4;
            3'd5: return 5'd6;
            3'd6: return 5'd3;
            default: return 5'd2;
        endcase
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic [3:0] st);
        case (f3)
            3'd0: return st[0];
            3'd1: return !st[0];
            3'd4: return st[1] != st[3];
            3'd5: return st[1] == st[3];
            default: return 1'b0;
        endcase
    endfunction

    // kind: 0 R, 1 I-ALU, 2 load, 3 store, 4 branch
    task automatic model_dec(input logic [31:0] ins, output logic ok, output logic [4:0] op, output int kind);
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        ok = 1'b0; op = 5'd0; kind = -1;
        case (ins[6:0])
            7'h33: begin
                kind = 0;
                ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                op = f7 == 7'h20 ? (f3 == 3'd0 ? 5'd1 : 5'd7) : base_op(f3);
            end
            7'h13: begin
                kind = 1;
                ok = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                op = (f3 == 3'd5 && f7 == 7'h20) ? 5'd7 : base_op(f3);
            end
            7'h03: begin kind = 2; ok = f3 == 3'd2; end
            7'h23: begin kind = 3; ok = f3 == 3'd2; end
            7'h63: begin kind = 4; ok = f3 inside {3'd0, 3'd1, 3'd4, 3'd5}; op = 5'd1; end
            default: ;
        endcase
    endtask

    // push one entry per cycle the instruction occupies, FETCH first
    task automatic expand(input int k, input logic [31:0] ins);
        ent_t d, e, x;
        logic ok;
        logic [4:0] op;
        int kind;
        d = '0; d.ALUsrc = 1'b1; d.mRW = 1'b1;
        model_dec(ins, ok, op, kind);
        q[k].push_back(d);
        q[k].push_back(d);
        if (!ok) begin
            if (k == 0) halted[k] = 1'b1;
            else begin x = d; x.pc_en = 1'b1; q[k].push_back(x); end
            return;
        end
        e = d;
        e.ALUop = op;
        e.ALUsrc = kind == 0 || kind == 4;
        e.immsrc = kind == 3 ? 2'b01 : kind == 4 ? 2'b10 : 2'b00;
        if (kind == 4) begin
            e.pc_en = 1'b1; e.br = 1'b1; e.f3 = ins[14:12];
            q[k].push_back(e);
            return;
        end
        q[k].push_back(e);
        if (kind == 2 || kind == 3) begin
            x = e; x.mRW = kind == 2; x.pc_en = kind == 3;
            q[k].push_back(x);
        end
        if (kind != 3) begin
            x = e; x.regRW = 1'b1; x.wb = kind == 2; x.pc_en = 1'b1;
            q[k].push_back(x);
        end
    endtask

    task automatic check_cycle(input int k, input obs_t a);
        obs_t ex;
        ent_t e;
        logic [31:0] mask = k == 0 ? 32'hFFFFFFFF : 32'h0000000F;
        if (rst_s) begin q[k].delete(); halted[k] = 1'b0; mc[k] = 32'd0; end
        if (q[k].size() == 0 && !halted[k]) expand(k, instr);
        if (q[k].size() == 0) begin
            ex = '{regRW: 1'b0, ALUsrc: 1'b1, immsrc: 2'b00, ALUop: 5'd0, mRW: 1'b1, wb: 1'b0,
                   pcsrc: 1'b1, pc_en: 1'b0, illegal: 1'b1, retired: mc[k]};
        end else begin
            e = q[k].pop_front();
            ex = '{regRW: e.regRW, ALUsrc: e.ALUsrc, immsrc: e.immsrc, ALUop: e.ALUop, mRW: e.mRW, wb: e.wb,
                   pcsrc: !(e.br && taken(e.f3, status)), pc_en: e.pc_en, illegal: 1'b0, retired: mc[k]};
        end
        checks++;
        if (a !== ex) begin
            errors++;
            $display("FAIL ctrl dut%0d cycle %0d: got %h, expected %h (fields regRW,ALUsrc,immsrc,ALUop,mRW,wb,pcsrc,pc_en,illegal,retired)",
                     k, cyc, a, ex);
        end
        last[k] = a;
        if (ex.pc_en) mc[k] = (mc[k] + 32'd1) & mask;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        check_cycle(0, a0);
        check_cycle(1, a1);
        rst_s = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input logic [31:0] ins, input logic [3:0] st, input int n);
        instr = ins;
        status = st;
        tick();
        instr = JUNK;
        repeat (n - 1) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        tick();
        tick();
        lit("reset_retired", last[0].retired, 0);
        lit("reset_mRW", {31'd0, last[0].mRW}, 1);
        rst = 1'b0;
        run(ADD, 4'b0000, 4);
        lit("add_wb_pc_en", {31'd0, last[0].pc_en}, 1);
        lit("add_wb_regRW", {31'd0, last[0].regRW}, 1);
        run(SUB, 4'b0000, 4);
        lit("retired_after_add", last[0].retired, 1);
        run(ADDI, 4'b0000, 4);
        run(SRAI, 4'b0000, 4);
        lit("srai_aluop", {27'd0, last[0].ALUop}, 7);
        run(LW, 4'b0000, 5);
        lit("lw_wb", {31'd0, last[0].wb}, 1);
        run(SW, 4'b0000, 4);
        lit("sw_mem_mRW", {31'd0, last[0].mRW}, 0);
        run(BEQ, 4'b0001, 3);
        lit("beq_taken_pcsrc", {31'd0, last[0].pcsrc}, 0);
        run(BEQ, 4'b0000, 3);
        lit("beq_not_taken_pcsrc", {31'd0, last[0].pcsrc}, 1);
        run(BNE, 4'b0000, 3);
        run(BLT, 4'b1000, 3);
        lit("blt_taken_pcsrc", {31'd0, last[0].pcsrc}, 0);
        run(BGE, 4'b1000, 3);
        run(BGE, 4'b0010, 3);
        lit("retired_before_rst", last[0].retired, 11);
        instr = LW;
        tick();
        instr = JUNK;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        instr = ADD;
        tick();
        lit("rst_mid_lw_retired", last[0].retired, 0);
        lit("rst_mid_lw_regRW", {31'd0, last[0].regRW}, 0);
        instr = JUNK;
        repeat (3) tick();
        tick();
        tick();
        tick();
        lit("halt_illegal", {31'd0, last[0].illegal}, 1);
        lit("nop_pc_en", {31'd0, last[1].pc_en}, 1);
        lit("nop_regRW", {31'd0, last[1].regRW}, 0);
        repeat (19) tick();
        lit("halt_pc_en", {31'd0, last[0].pc_en}, 0);
        lit("halt_retired", last[0].retired, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(ADD, 4'b0000, 4);
        lit("rst_clears_illegal", {31'd0, last[0].illegal}, 0);
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: run(ADD, 4'b0000, 4);
                1: run(ADDI, 4'b0000, 4);
                2: run(SW, 4'b0000, 4);
                default: run(BEQ, 4'b0000, 3);
            endcase
        end
        instr = ADD;
        tick();
        lit("retired_17", last[0].retired, 17);
        lit("retired_wrap_4bit", last[1].retired, 1);
        instr = JUNK;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
